// File: rtl/mul_div_pkg.sv
// Shared constants for the multi-cycle multiply/divide engine.
package mul_div_pkg;
  localparam int MD_DATA_W = 16;
  localparam int MD_ADDR_W = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [MD_DATA_W-1:0] DIV0_QUOT = 16'hFFFF;
endpackage

// File: rtl/mul_div_unit_if.sv
// Request port plus the regfile write-port pair driven by mul_div_unit.
interface mul_div_unit_if import mul_div_pkg::*; #(
  parameter int DATA_W = MD_DATA_W,
  parameter int ADDR_W = MD_ADDR_W
);
  logic              start;
  logic              op;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic [ADDR_W-1:0] dstAddr;
  logic              busy;
  logic              done;
  logic              divByZero;
  logic              wr;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              wrR15;
  logic [DATA_W-1:0] wrDataR15;

  modport master (
    output start, op, opA, opB, dstAddr,
    input  busy, done, divByZero, wr, wrAddr, wrData, wrR15, wrDataR15
  );
  modport slave (
    input  start, op, opA, opB, dstAddr,
    output busy, done, divByZero, wr, wrAddr, wrData, wrR15, wrDataR15
  );
endinterface

// File: rtl/mul_div_step.sv
// One shift-add multiply or restoring-divide iteration on the {hi,lo} accumulator.
module mul_div_step import mul_div_pkg::*; #(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic                op,
  input  logic [DATA_W-1:0]   opnd,
  input  logic [2*DATA_W-1:0] acc,
  output logic [2*DATA_W-1:0] accNxt
);
  logic [DATA_W-1:0] hi, lo, diffLo;
  logic [DATA_W:0]   sum, pr;
  logic              borrow;

  assign hi = acc[2*DATA_W-1:DATA_W];
  assign lo = acc[DATA_W-1:0];

  // Multiply: lo holds the multiplier, shifted out LSB-first as product bits shift in.
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);

  // Divide: hi is the remainder, lo the dividend that becomes the quotient.
  // Remainder is always below the divisor, so the difference fits in DATA_W bits.
  assign pr     = {hi, lo[DATA_W-1]};
  assign borrow = pr < {1'b0, opnd};
  assign diffLo = pr[DATA_W-1:0] - opnd;

  always_comb begin
    accNxt = {sum, lo[DATA_W-1:1]};
    if (op == OP_DIV)
      accNxt = {(borrow ? pr[DATA_W-1:0] : diffLo), lo[DATA_W-2:0], ~borrow};
  end
endmodule

// File: rtl/mul_div_unit.sv
// 16-bit unsigned multi-cycle multiply/divide engine feeding the regfile write pair.
module mul_div_unit import mul_div_pkg::*; #(
  parameter int DATA_W = MD_DATA_W,
  parameter int ADDR_W = MD_ADDR_W,
  parameter int ITER   = DATA_W
) (
  input logic          clk,
  input logic          rst,
  mul_div_unit_if.slave bus
);
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  logic [1:0]          state, stateNxt;
  logic                opReg, dz, isDz, lastIter;
  logic [DATA_W-1:0]   opnd;
  logic [ADDR_W-1:0]   dstReg;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc, accNxt;

  assign isDz     = (bus.op == OP_DIV) && (bus.opB == '0);
  assign lastIter = cnt == CNT_W'(ITER-1);

  mul_div_step #(.DATA_W(DATA_W)) u_step (
    .op(opReg), .opnd(opnd), .acc(acc), .accNxt(accNxt)
  );

  always_comb begin
    stateNxt = state;
    case (state)
      S_IDLE:  if (bus.start) stateNxt = isDz ? S_WB : S_RUN;
      S_RUN:   if (lastIter) stateNxt = S_WB;
      S_WB:    stateNxt = S_IDLE;
      default: stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      opReg         <= OP_MUL;
      dz            <= 1'b0;
      opnd          <= '0;
      dstReg        <= '0;
      cnt           <= '0;
      acc           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.divByZero <= 1'b0;
      bus.wr        <= 1'b0;
      bus.wrR15     <= 1'b0;
      bus.wrAddr    <= '0;
      bus.wrData    <= '0;
      bus.wrDataR15 <= '0;
    end else begin
      state <= stateNxt;
      // Strobes are registered from WB, so busy also covers the cycle they are out.
      bus.busy      <= (stateNxt != S_IDLE) || (state == S_WB);
      bus.done      <= state == S_WB;
      bus.wr        <= state == S_WB;
      bus.wrR15     <= (state == S_WB) && (dstReg != '0);
      bus.divByZero <= (state == S_WB) && dz;

      if (state == S_IDLE && bus.start) begin
        opReg  <= bus.op;
        dz     <= isDz;
        dstReg <= bus.dstAddr;
        cnt    <= '0;
        opnd   <= (bus.op == OP_DIV) ? bus.opB : bus.opA;
        acc    <= {{DATA_W{1'b0}}, ((bus.op == OP_DIV) ? bus.opA : bus.opB)};
      end else if (state == S_RUN) begin
        acc <= accNxt;
        cnt <= cnt + 1'b1;
      end

      // On divide-by-zero the untouched dividend still sits in acc low.
      if (state == S_WB) begin
        bus.wrAddr    <= dstReg;
        bus.wrData    <= dz ? DATA_W'(DIV0_QUOT) : acc[DATA_W-1:0];
        bus.wrDataR15 <= dz ? acc[DATA_W-1:0] : acc[2*DATA_W-1:DATA_W];
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit with hand-computed results.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nChk = 0;
  int   nErr = 0;

  mul_div_unit_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  mul_div_unit #(.DATA_W(16), .ADDR_W(3), .ITER(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an op at the next edge and check the write-back; optionally fire a
  // stray start with different operands at cycle 5.
  task automatic doOp(input string nm, input logic op, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] dst, input int expLat, input logic [15:0] expLo,
                      input logic [15:0] expHi, input logic expR15, input logic expDz,
                      input logic glitch);
    int lat;
    bus.start = 1'b1; bus.op = op; bus.opA = a; bus.opB = b; bus.dstAddr = dst;
    tick();
    bus.start = 1'b0;
    chk({nm, "_busyUp"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.done && lat < 40) begin
      if (glitch && lat == 4) begin
        bus.start = 1'b1; bus.op = 1'b1; bus.opA = 16'h0009; bus.opB = 16'h0003; bus.dstAddr = 3'd6;
      end
      tick();
      bus.start = 1'b0;
      lat++;
    end
    chk({nm, "_lat"}, 32'(lat), 32'(expLat));
    chk({nm, "_wr"}, 32'(bus.wr), 32'd1);
    chk({nm, "_wrAddr"}, 32'(bus.wrAddr), 32'(dst));
    chk({nm, "_wrData"}, 32'(bus.wrData), 32'(expLo));
    chk({nm, "_wrR15"}, 32'(bus.wrR15), 32'(expR15));
    if (expR15) chk({nm, "_wrDataR15"}, 32'(bus.wrDataR15), 32'(expHi));
    chk({nm, "_divByZero"}, 32'(bus.divByZero), 32'(expDz));
    tick();
    chk({nm, "_strobesDrop"}, 32'({bus.done, bus.wr, bus.wrR15, bus.divByZero}), 32'd0);
    chk({nm, "_busyDown"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit sawWr;
    bus.start = 1'b0; bus.op = 1'b0; bus.opA = '0; bus.opB = '0; bus.dstAddr = '0;
    repeat (3) tick();
    chk("rst_strobes", 32'({bus.busy, bus.done, bus.divByZero, bus.wr, bus.wrR15}), 32'd0);
    chk("rst_wrAddr", 32'(bus.wrAddr), 32'd0);
    chk("rst_wrData", 32'(bus.wrData), 32'd0);
    chk("rst_wrDataR15", 32'(bus.wrDataR15), 32'd0);
    rst = 1'b0;
    tick();

    doOp("mul",     1'b0, 16'h00FF, 16'h0040, 3'd3, 17, 16'h3FC0, 16'h0000, 1'b1, 1'b0, 1'b0);
    doOp("mulOvf",  1'b0, 16'hFFFF, 16'hFFFF, 3'd5, 17, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    doOp("div",     1'b1, 16'h0050, 16'h0007, 3'd2, 17, 16'h000B, 16'h0003, 1'b1, 1'b0, 1'b0);
    doOp("divZero", 1'b1, 16'h1234, 16'h0000, 3'd4,  1, 16'hFFFF, 16'h1234, 1'b1, 1'b1, 1'b0);
    doOp("mulR0",   1'b0, 16'h0100, 16'h0100, 3'd0, 17, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);
    doOp("divMax",  1'b1, 16'hFFFF, 16'h0001, 3'd7, 17, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    doOp("divSmall",1'b1, 16'h0005, 16'h0009, 3'd1, 17, 16'h0000, 16'h0005, 1'b1, 1'b0, 1'b0);
    doOp("ignStart",1'b0, 16'h00FF, 16'h0040, 3'd3, 17, 16'h3FC0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Abort a divide mid-RUN with reset.
    bus.start = 1'b1; bus.op = 1'b1; bus.opA = 16'h0050; bus.opB = 16'h0007; bus.dstAddr = 3'd2;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    sawWr = 1'b0;
    tick();
    rst = 1'b0;
    repeat (25) begin
      tick();
      if (bus.wr || bus.wrR15 || bus.done) sawWr = 1'b1;
    end
    chk("abort_noWrite", 32'(sawWr), 32'd0);
    doOp("afterAbort", 1'b1, 16'h0050, 16'h0007, 3'd2, 17, 16'h000B, 16'h0003, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nChk, nErr);
    $finish;
  end
endmodule
